// File: rtl/letter_shift_pipeline.sv
// Rotor-driven Caesar shift pipeline: one stage per rotor, odometer-stepped
// rotor positions captured with each character and applied stage by stage.
module letter_shift_pipeline #(
    parameter int NUM_ROTORS = 3,
    parameter int ALPHA      = 26,
    parameter int CHAR_W     = 7,
    localparam int POS_W     = (ALPHA > 1) ? $clog2(ALPHA) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        encrypt,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHAR_W-1:0]           char_in,
    input  logic                        load_pos,
    input  logic [NUM_ROTORS*POS_W-1:0] rotor_pos_in,
    output logic [NUM_ROTORS*POS_W-1:0] rotor_pos_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHAR_W-1:0]           letter_out,
    output logic                        out_err
);

    localparam int RW = NUM_ROTORS * POS_W;
    localparam logic [CHAR_W:0]  ALPHA_X = (CHAR_W + 1)'(ALPHA);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(ALPHA - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready
    // are both high at that port; ready never depends on the same port's valid.

    logic [CHAR_W-1:0] data_q  [NUM_ROTORS];
    logic              err_q   [NUM_ROTORS];
    logic              enc_q   [NUM_ROTORS];
    logic              valid_q [NUM_ROTORS];
    logic [RW-1:0]     offs_q  [NUM_ROTORS];

    logic [CHAR_W-1:0] src_data  [NUM_ROTORS];
    logic              src_err   [NUM_ROTORS];
    logic              src_enc   [NUM_ROTORS];
    logic              src_valid [NUM_ROTORS];
    logic [RW-1:0]     src_offs  [NUM_ROTORS];
    logic [CHAR_W-1:0] nxt_data  [NUM_ROTORS];

    logic [POS_W-1:0]  rotor_q    [NUM_ROTORS];
    logic [POS_W-1:0]  rotor_step [NUM_ROTORS];
    logic [POS_W-1:0]  rotor_load [NUM_ROTORS];
    logic [RW-1:0]     rotor_flat;

    logic stall;
    logic accept;
    logic char_illegal;

    function automatic logic [CHAR_W-1:0] shift_letter(input logic [CHAR_W-1:0] a,
                                                       input logic [POS_W-1:0]  p,
                                                       input logic              enc);
        logic [CHAR_W:0] s;
        logic [CHAR_W:0] pe;
        pe = (CHAR_W + 1)'(p);
        if (enc) begin
            s = {1'b0, a} + pe;
            if (s >= ALPHA_X) s = s - ALPHA_X;
        end else if ({1'b0, a} >= pe) begin
            s = {1'b0, a} - pe;
        end else begin
            s = {1'b0, a} + ALPHA_X - pe;
        end
        return s[CHAR_W-1:0];
    endfunction

    assign out_valid     = valid_q[NUM_ROTORS-1];
    assign letter_out    = data_q[NUM_ROTORS-1];
    assign out_err       = err_q[NUM_ROTORS-1];
    assign rotor_pos_out = rotor_flat;

    assign stall        = out_valid && !out_ready;
    assign in_ready     = !reset && !stall && !load_pos;
    assign accept       = in_valid && in_ready;
    assign char_illegal = 32'(char_in) >= ALPHA;

    for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_stage
        assign rotor_flat[k*POS_W +: POS_W] = rotor_q[k];
        assign rotor_load[k] = (32'(rotor_pos_in[k*POS_W +: POS_W]) >= ALPHA)
                             ? '0 : rotor_pos_in[k*POS_W +: POS_W];
        // Stage 0 snapshots the live rotor positions; later stages reuse that snapshot.
        if (k == 0) begin : g_head
            assign src_data[k]  = char_in;
            assign src_err[k]   = char_illegal;
            assign src_enc[k]   = encrypt;
            assign src_valid[k] = accept;
            assign src_offs[k]  = rotor_flat;
        end else begin : g_body
            assign src_data[k]  = data_q[k-1];
            assign src_err[k]   = err_q[k-1];
            assign src_enc[k]   = enc_q[k-1];
            assign src_valid[k] = valid_q[k-1];
            assign src_offs[k]  = offs_q[k-1];
        end
        assign nxt_data[k] = src_err[k] ? src_data[k]
                           : shift_letter(src_data[k], src_offs[k][k*POS_W +: POS_W], src_enc[k]);
    end

    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int k = 0; k < NUM_ROTORS; k++) begin
            rotor_step[k] = rotor_q[k];
            if (carry) begin
                if (rotor_q[k] == POS_MAX) begin
                    rotor_step[k] = '0;
                end else begin
                    rotor_step[k] = rotor_q[k] + POS_W'(1);
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_ROTORS; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                err_q[k]   <= 1'b0;
                enc_q[k]   <= 1'b0;
                offs_q[k]  <= '0;
                rotor_q[k] <= '0;
            end
        end else begin
            if (!stall) begin
                for (int k = 0; k < NUM_ROTORS; k++) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= nxt_data[k];
                        err_q[k]  <= src_err[k];
                        enc_q[k]  <= src_enc[k];
                        offs_q[k] <= src_offs[k];
                    end
                end
            end
            // A load wins even while the pipeline is stalled.
            if (load_pos) begin
                for (int k = 0; k < NUM_ROTORS; k++) rotor_q[k] <= rotor_load[k];
            end else if (accept && !char_illegal) begin
                for (int k = 0; k < NUM_ROTORS; k++) rotor_q[k] <= rotor_step[k];
            end
        end
    end

endmodule

// File: tb/tb_letter_shift_pipeline.sv
// Bench for letter_shift_pipeline: directed scenarios plus random traffic,
// checked against an odometer/modular-arithmetic reference model.
module tb_letter_shift_pipeline;

    localparam int N  = 3;
    localparam int A  = 26;
    localparam int CW = 7;
    localparam int PW = 5;
    localparam int MODN = A * A * A;

    logic            clk = 1'b0;
    logic            rst;
    logic            enc;
    logic            iv;
    logic            in_ready;
    logic [CW-1:0]   ch;
    logic            lp;
    logic [N*PW-1:0] rpi;
    logic [N*PW-1:0] rotor_pos_out;
    logic            out_valid;
    logic            ordy;
    logic [CW-1:0]   letter_out;
    logic            out_err;

    letter_shift_pipeline #(.NUM_ROTORS(N), .ALPHA(A), .CHAR_W(CW)) dut (
        .clk(clk), .reset(rst), .encrypt(enc), .in_valid(iv), .in_ready(in_ready),
        .char_in(ch), .load_pos(lp), .rotor_pos_in(rpi), .rotor_pos_out(rotor_pos_out),
        .out_valid(out_valid), .out_ready(ordy), .letter_out(letter_out), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pos_val = 0;          // rotor positions as one base-A odometer number
    bit ref_v [N];            // occupancy of each pipeline slot
    logic [CW:0] exp_q [$];   // {err, letter} in acceptance order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int digit(input int v, input int k);
        int d = v;
        for (int i = 0; i < k; i++) d = d / A;
        return d % A;
    endfunction

    function automatic logic [N*PW-1:0] model_pack();
        logic [N*PW-1:0] r = '0;
        for (int k = 0; k < N; k++) r[k*PW +: PW] = PW'(digit(pos_val, k));
        return r;
    endfunction

    function automatic int load_val(input logic [N*PW-1:0] v);
        int acc = 0;
        int w = 1;
        for (int k = 0; k < N; k++) begin
            int f = int'(v[k*PW +: PW]);
            if (f >= A) f = 0;
            acc += f * w;
            w *= A;
        end
        return acc;
    endfunction

    function automatic logic [CW:0] model_item(input logic [CW-1:0] c, input logic e);
        int sum = 0;
        int r;
        if (int'(c) >= A) return {1'b1, c};
        for (int k = 0; k < N; k++) sum += digit(pos_val, k);
        r = e ? (int'(c) + sum) % A : (((int'(c) - sum) % A) + A) % A;
        return {1'b0, CW'(r)};
    endfunction

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic step(output bit acc);
        bit exp_ov, stall, exp_ir, xfer;
        #1;
        exp_ov = ref_v[N-1];
        stall  = exp_ov && !ordy;
        exp_ir = !rst && !stall && !lp;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("rotor_pos", 32'(rotor_pos_out), 32'(model_pack()));
        if (exp_ov) begin
            if (exp_q.size() == 0) check("queue_underflow", 32'(exp_q.size()), 32'd1);
            else check("letter", 32'({out_err, letter_out}), 32'(exp_q[0]));
        end
        acc  = iv && exp_ir;
        xfer = exp_ov && ordy && !rst;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) ref_v[k] = 1'b0;
            exp_q.delete();
            pos_val = 0;
        end else begin
            if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(model_item(ch, enc));
            if (!stall) begin
                for (int k = N - 1; k > 0; k--) ref_v[k] = ref_v[k-1];
                ref_v[0] = acc;
            end
            if (lp) pos_val = load_val(rpi);
            else if (acc && int'(ch) < A) pos_val = (pos_val + 1) % MODN;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        bit a;
        iv = 1'b0; lp = 1'b0; ordy = 1'b1;
        for (int i = 0; i < cycles; i++) step(a);
    endtask

    task automatic send(input logic [CW-1:0] c, input logic e);
        bit a = 1'b0;
        int guard = 0;
        iv = 1'b1; ch = c; enc = e;
        while (!a && guard < 50) begin
            step(a);
            guard++;
        end
        if (!a) check("send_timeout", 32'(guard), 32'd0);
        iv = 1'b0;
    endtask

    task automatic load(input logic [N*PW-1:0] v);
        bit a;
        lp = 1'b1; rpi = v;
        step(a);
        lp = 1'b0;
    endtask

    task automatic wait_out_check(input string tag, input logic [CW:0] exp);
        int guard = 0;
        bit a;
        iv = 1'b0; ordy = 1'b1;
        while (!out_valid && guard < 10) begin
            step(a);
            guard++;
        end
        check(tag, 32'({out_err, letter_out}), 32'(exp));
        step(a);
    endtask

    initial begin
        bit a;
        int sent;
        int cyc;
        logic [CW-1:0] seq [10];
        rst = 1'b1; enc = 1'b1; iv = 1'b0; ch = '0; lp = 1'b0; rpi = '0; ordy = 1'b1;
        for (int k = 0; k < N; k++) ref_v[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        iv = 1'b1; lp = 1'b1; ordy = 1'b0;
        step(a);
        check("reset_letter", 32'({out_err, letter_out}), 32'd0);
        rst = 1'b0; iv = 1'b0; lp = 1'b0; ordy = 1'b1;

        // Three zeros back to back from reset.
        iv = 1'b1; ch = '0; enc = 1'b1;
        for (int i = 0; i < 3; i++) step(a);
        iv = 1'b0;
        check("rotor_after_three", 32'(rotor_pos_out), 32'd3);
        idle(6);

        // Double carry on the odometer, then the round trip.
        load({5'd0, 5'd25, 5'd25});
        send(7'd3, 1'b1);
        check("rotor_after_carry", 32'(rotor_pos_out), 32'({5'd1, 5'd0, 5'd0}));
        wait_out_check("enc_carry", 8'd1);
        load({5'd0, 5'd25, 5'd25});
        send(7'd1, 1'b0);
        wait_out_check("dec_round_trip", 8'd3);

        // Ten-character stream with a four-cycle downstream stall.
        for (int i = 0; i < 10; i++) seq[i] = CW'($urandom_range(0, A - 1));
        sent = 0; cyc = 0; enc = 1'b1;
        while ((sent < 10 || exp_q.size() > 0) && cyc < 60) begin
            iv   = (sent < 10);
            ch   = (sent < 10) ? seq[sent] : '0;
            ordy = !(cyc >= 4 && cyc <= 7);
            step(a);
            if (a) sent++;
            cyc++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        idle(4);

        // Illegal character, then a legal one on unchanged positions.
        send(7'd30, 1'b1);
        send(7'd4, 1'b1);
        wait_out_check("illegal_pass", 8'h9E);
        idle(4);

        // Out-of-range load fields, and a load during a stall.
        load({5'd31, 5'd2, 5'd27});
        iv = 1'b1; ch = 7'd9; ordy = 1'b0;
        for (int i = 0; i < 5; i++) step(a);
        iv = 1'b0;
        load({5'd3, 5'd4, 5'd5});
        idle(6);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ch   = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(A, 127)) : CW'($urandom_range(0, A - 1));
            enc  = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            lp   = ($urandom_range(0, 24) == 0);
            rpi  = (N*PW)'($urandom);
            step(a);
        end
        idle(8);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two characters in flight.
        iv = 1'b1; ch = 7'd5; enc = 1'b1;
        step(a);
        step(a);
        iv = 1'b0; rst = 1'b1;
        step(a);
        rst = 1'b0;
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_rotor", 32'(rotor_pos_out), 32'd0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
